// File: rtl/regfile_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_pkg
// Description : Shared widths and the write-request record used by both
//               producers, the writeback queue and the controller.
// Revision    : 1.0  initial release
// ============================================================================
package regfile_wb_pkg;

  localparam int REG_AW   = 3;
  localparam int REG_DW   = 16;
  localparam int NUM_REGS = 2 ** REG_AW;

  // One register write: destination plus value.
  typedef struct packed {
    logic [REG_AW-1:0] adr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

  localparam int c_REQ_W = REG_AW + REG_DW;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : DEPTH x WIDTH circular buffer with push/pop, occupancy count
//               and full/empty flags. Pointers wrap at DEPTH, so DEPTH does
//               not need to be a power of two.
// Revision    : 1.0  initial release
// ============================================================================
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = c_REQ_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [2:0]       o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_PW = $clog2(DEPTH);

  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [2:0]       r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
    return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
  endfunction

  // Overflow/underflow requests are ignored so the pointers never corrupt.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  assign o_full    = (r_count == 3'(DEPTH));
  assign o_empty   = (r_count == 3'd0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; push and pop together keep count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 3'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb
// Description : Writeback controller for the 8x16 register file. Arbitrates
//               load/ALU write requests (load wins), queues them in order,
//               retires one write per cycle and keeps a per-register
//               pending-write scoreboard for RAW stall detection.
//               AW/DW must match the package widths of wr_req_t.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = REG_DW,
  parameter int AW    = REG_AW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_adr,
  input  logic [DW-1:0]   a_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [AW-1:0]   m_adr,
  input  logic [DW-1:0]   m_data,
  input  logic            hold,
  output logic [AW-1:0]   w_adr,
  output logic [DW-1:0]   w,
  output logic            we,
  output logic [2**AW-1:0] pend,
  output logic [2:0]      count
);

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  wr_req_t             w_push_req;
  wr_req_t             w_head;
  logic [c_REQ_W-1:0]  w_head_bits;

  // Readiness depends only on the registered occupancy, never on a pop.
  assign m_ready = !w_full;
  assign a_ready = !w_full && !m_valid;
  assign w_push  = (m_valid && m_ready) || (a_valid && a_ready);
  assign w_pop   = !w_empty && !hold;

  // Load has priority; when the ALU is accepted m_valid is necessarily low.
  always_comb begin
    w_push_req      = '0;
    w_push_req.adr  = m_valid ? m_adr  : a_adr;
    w_push_req.data = m_valid ? m_data : a_data;
  end

  assign w_head = w_head_bits;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_REQ_W)
  ) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .i_push    (w_push),
    .i_wr_data (w_push_req),
    .i_pop     (w_pop),
    .o_rd_data (w_head_bits),
    .o_count   (count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Register-file write port: one-cycle we pulse per retired entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we    <= 1'b0;
      w_adr <= '0;
      w     <= '0;
    end else if (w_pop) begin
      we    <= 1'b1;
      w_adr <= w_head.adr;
      w     <= w_head.data;
    end else begin
      we    <= 1'b0;
    end
  end

  // Scoreboard: counts queued writes per register, cleared at the pop edge.
  for (genvar gi = 0; gi < 2 ** AW; gi++) begin : g_sb
    logic       w_inc;
    logic       w_dec;
    logic [2:0] r_cnt;

    assign w_inc    = w_push && (w_push_req.adr == AW'(gi));
    assign w_dec    = w_pop && (w_head.adr == AW'(gi));
    assign pend[gi] = (r_cnt != 3'd0);

    // Simultaneous inc and dec cancel out.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) r_cnt <= 3'd0;
      else       r_cnt <= r_cnt + 3'(w_inc) - 3'(w_dec);
    end
  end

endmodule
`default_nettype wire
